// File: rtl/pattern_detector_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pattern_detector_pkg -- shared defaults and helpers for the pattern detector
// Revision 1.0
// ----------------------------------------------------------------------------
package pattern_detector_pkg;

  localparam int unsigned DEFAULT_PAT_LEN = 4;
  localparam int unsigned DEFAULT_CNT_W   = 8;
  localparam logic [3:0]  DEFAULT_PAT     = 4'b1011;

  // Width needed to hold a fill count of 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_detector_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter -- saturating event counter with a sticky all-ones flag
// Revision 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Clear dominates a coincident increment.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc && !(&count_q)) begin
        count_d = count_q + 1'b1;
      end
      sat_d = sat_q || (&count_d);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule
`default_nettype wire

// File: rtl/pattern_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pattern_detector -- serial bit-pattern detector with match counter
// Revision 1.0
// ----------------------------------------------------------------------------
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEFAULT_PAT_LEN,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  localparam int unsigned        FILL_W    = fill_width(PAT_LEN);
  localparam logic [PAT_LEN-1:0] RST_PAT   = PAT_LEN'(DEFAULT_PAT);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_THR  = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] sh_q, sh_d;
  logic [PAT_LEN-1:0] window;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q;
  logic               accept;
  logic               match;

  // The window is the history as it will look once the current bit is taken.
  always_comb begin
    accept = in_valid && !pat_load;
    window = {sh_q[PAT_LEN-2:0], in};
    match  = accept && (window == pat_q) && (fill_q >= FILL_THR);

    pat_d  = pat_q;
    sh_d   = sh_q;
    fill_d = fill_q;

    if (pat_load) begin
      pat_d  = pat_in;
      sh_d   = '0;
      fill_d = '0;
    end else if (accept) begin
      sh_d = window;
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q  <= RST_PAT;
      sh_q   <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      sh_q   <= sh_d;
      fill_q <= fill_d;
      out_q  <= match;
    end
  end

  assign out = out_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (cnt_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pattern_detector -- directed table, corner sequences and random checks
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pattern_detector;

  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_b;
  logic          in_valid;
  logic          pat_load;
  logic [PL-1:0] pat_in;
  logic          overlap;
  logic          cnt_clr;

  logic          out8, out2;
  logic [7:0]    cnt8;
  logic [1:0]    cnt2;
  logic          sat8, sat2;

  always #5 clk = ~clk;

  pattern_detector #(.PAT_LEN(PL), .CNT_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .in(in_b), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .cnt_clr(cnt_clr), .out(out8), .match_count(cnt8), .cnt_sat(sat8)
  );

  pattern_detector #(.PAT_LEN(PL), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in(in_b), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .cnt_clr(cnt_clr), .out(out2), .match_count(cnt2), .cnt_sat(sat2)
  );

  // Reference model: keeps the list of bits that may still form a match.
  bit            m_hist[$];
  logic [PL-1:0] m_pat;
  bit            m_out;
  int            m_cnt8, m_cnt2;
  bit            m_sat8, m_sat2;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_pat  = 4'b1011;
    m_out  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_sat8 = 1'b0;
    m_sat2 = 1'b0;
  endfunction

  function automatic void model_edge();
    bit hit;
    hit = 1'b0;
    if (pat_load) begin
      m_pat = pat_in;
      m_hist.delete();
    end else if (in_valid) begin
      m_hist.push_back(in_b);
      if (m_hist.size() >= PL) begin
        hit = 1'b1;
        for (int k = 0; k < PL; k++)
          if (m_hist[m_hist.size() - PL + k] != m_pat[PL-1-k]) hit = 1'b0;
      end
      if (m_hist.size() > PL) void'(m_hist.pop_front());
      if (hit && !overlap) m_hist.delete();
    end
    m_out = hit;
    if (cnt_clr) begin
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
      if (m_cnt8 == 255) m_sat8 = 1'b1;
      if (m_cnt2 == 3)   m_sat2 = 1'b1;
    end
  endfunction

  task automatic check_all();
    check("out8", 32'(out8), 32'(m_out));
    check("out2", 32'(out2), 32'(m_out));
    check("cnt8", 32'(cnt8), 32'(m_cnt8));
    check("sat8", 32'(sat8), 32'(m_sat8));
    check("cnt2", 32'(cnt2), 32'(m_cnt2));
    check("sat2", 32'(sat2), 32'(m_sat2));
  endtask

  task automatic step(input bit v, input bit b, input bit ld,
                      input logic [PL-1:0] pi, input bit clr);
    in_valid = v;
    in_b     = b;
    pat_load = ld;
    pat_in   = pi;
    cnt_clr  = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  typedef struct {
    bit            v;
    bit            b;
    bit            ld;
    logic [PL-1:0] pi;
    bit            ovl;
    bit            clr;
    bit            eo;
    int            ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit b, bit ld, logic [PL-1:0] pi,
                              bit ovl, bit clr, bit eo, int ec);
    vec_t r;
    r.v = v; r.b = b; r.ld = ld; r.pi = pi;
    r.ovl = ovl; r.clr = clr; r.eo = eo; r.ec = ec;
    return r;
  endfunction

  initial begin
    // Overlapping detection on the default pattern
    tbl.push_back(mk(1,1,0,0,1,0,0,0)); tbl.push_back(mk(1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0,0)); tbl.push_back(mk(1,1,0,0,1,0,1,1));
    tbl.push_back(mk(1,0,0,0,1,0,0,1)); tbl.push_back(mk(1,1,0,0,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0,1,2));
    // Reload the same pattern and clear; then non-overlapping
    tbl.push_back(mk(0,0,1,4'b1011,1,1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0)); tbl.push_back(mk(1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0)); tbl.push_back(mk(1,1,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,1)); tbl.push_back(mk(1,1,0,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,1));
    // New pattern 0110 with in_valid gaps
    tbl.push_back(mk(0,0,1,4'b0110,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,0,0,1)); tbl.push_back(mk(0,1,0,0,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0,0,1)); tbl.push_back(mk(0,0,0,0,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,1,0,0,1)); tbl.push_back(mk(1,1,0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,0,1)); tbl.push_back(mk(1,0,0,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,1,0,0,2));
    // Load coincident with a bit that would otherwise complete 0110
    tbl.push_back(mk(1,1,0,0,1,0,0,2)); tbl.push_back(mk(1,1,0,0,1,0,0,2));
    tbl.push_back(mk(1,0,1,4'b0110,1,0,0,2));
    tbl.push_back(mk(1,0,0,0,1,0,0,2));

    rstn = 1'b0; in_b = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    pat_in = '0; overlap = 1'b1; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #1 rstn = 1'b1;

    foreach (tbl[i]) begin
      overlap = tbl[i].ovl;
      step(tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].pi, tbl[i].clr);
      check("tbl_out", 32'(out8), 32'(tbl[i].eo));
      check("tbl_cnt", 32'(cnt8), 32'(tbl[i].ec));
    end

    // Asynchronous reset while out is high, then reset mid-pattern
    do_reset();
    overlap = 1'b1;
    step(1,1,0,0,0); step(1,0,0,0,0); step(1,1,0,0,0); step(1,1,0,0,0);
    check("pre_rst_out", 32'(out8), 32'd1);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    check("async_out", 32'(out8), 32'd0);
    check("async_cnt", 32'(cnt8), 32'd0);
    #1 rstn = 1'b1;
    step(1,1,0,0,0); step(1,0,0,0,0); step(1,1,0,0,0);
    do_reset();
    step(1,1,0,0,0);
    check("rst_hist_out", 32'(out8), 32'd0);
    step(1,0,0,0,0); step(1,1,0,0,0); step(1,1,0,0,0);
    check("rst_match_out", 32'(out8), 32'd1);
    check("rst_match_cnt", 32'(cnt8), 32'd1);

    // Two-bit counter saturation over four overlapping matches
    for (int m = 2; m <= 4; m++) begin
      step(1,0,0,0,0); step(1,1,0,0,0); step(1,1,0,0,0);
      check("sat_cnt2", 32'(cnt2), 32'd3 < 32'(m) ? 32'd3 : 32'(m));
      check("sat_flag2", 32'(sat2), 32'(m >= 3));
      check("sat_cnt8", 32'(cnt8), 32'(m));
    end
    step(0,0,0,0,1);
    check("clr_cnt2", 32'(cnt2), 32'd0);
    check("clr_sat2", 32'(sat2), 32'd0);

    // Clear coinciding with a completing bit
    step(1,0,0,0,0); step(1,1,0,0,0); step(1,1,0,0,1);
    check("clrhit_out", 32'(out8), 32'd1);
    check("clrhit_cnt", 32'(cnt8), 32'd0);
    step(0,0,0,0,0);
    check("clrhit_once", 32'(out8), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) overlap = $urandom_range(0, 1);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 49) == 0, PL'($urandom),
             $urandom_range(0, 59) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, match-counter width in bits (legal range 1..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 in  input  1  serial data bit.
REQ-006 in_valid  input  1  qualifies in; the block ignores in when in_valid=0.
REQ-007 pat_load  input  1  strobe: capture pat_in and clear the bit history.
REQ-008 pat_in  input  PAT_LEN  new pattern; MSB is the first bit expected on the line.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 cnt_clr  input  1  strobe: zero match_count and cnt_sat.
REQ-011 out  output  1  registered one-cycle match pulse.
REQ-012 match_count  output  CNT_W  number of matches since reset or the last cnt_clr.
REQ-013 cnt_sat  output  1  sticky flag: match_count reached all-ones.

Function
REQ-014 The block SHALL hold the pattern register pat_q, the shift register sh_q (PAT_LEN bits) and the fill counter fill_q (0..PAT_LEN).
REQ-015 For in_valid=1 and pat_load=0, the block SHALL update sh_q to {sh_q[PAT_LEN-2:0], in} and increment fill_q, saturating at PAT_LEN.
REQ-016 A match SHALL occur on an accepted bit when {sh_q[PAT_LEN-2:0], in} equals pat_q and fill_q >= PAT_LEN-1.
REQ-017 out SHALL be 1 in exactly the cycle following the edge that accepted the matching bit, and 0 in all other cycles.
REQ-018 Latency from the final pattern bit to out SHALL be 1 cycle.
REQ-019 On a match with overlap=1, fill_q SHALL remain PAT_LEN, so the next match can reuse trailing bits.
REQ-020 On a match with overlap=0, fill_q SHALL be set to 0, so the next match needs PAT_LEN fresh bits.
REQ-021 When in_valid=0, sh_q, fill_q and the detection state SHALL hold.
REQ-022 When pat_load=1, the block SHALL set pat_q <= pat_in, sh_q <= 0 and fill_q <= 0.
REQ-023 When pat_load=1 coincides with in_valid=1, pat_load SHALL win: the bit is discarded and out is 0 next cycle.
REQ-024 On each match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 with no wrap-around.
REQ-025 cnt_sat SHALL set when match_count becomes all-ones and SHALL stay set until cnt_clr or reset.
REQ-026 When cnt_clr=1, the block SHALL set match_count and cnt_sat to 0 regardless of a same-cycle match, which still pulses out.
REQ-027 A change on overlap SHALL take effect from the next accepted bit and SHALL NOT alter the history already stored.

Reset
REQ-028 While rstn=0, the block SHALL asynchronously force out=0, match_count=0, cnt_sat=0, sh_q=0 and fill_q=0.
REQ-029 While rstn=0, the block SHALL asynchronously force pat_q to DEFAULT_PAT resized to PAT_LEN (1011 for PAT_LEN=4).
REQ-030 Reset asserted mid-pattern SHALL discard all partial history; detection after release needs PAT_LEN new valid bits.
REQ-031 The first rising edge after rstn deasserts SHALL be able to accept a bit.

Structure
REQ-032 Shared package pattern_detector_pkg SHALL hold DEFAULT_PAT_LEN=4, DEFAULT_CNT_W=8 and DEFAULT_PAT=4'b1011.
REQ-033 Match counting plus sticky saturation SHALL live in one sub-module, sat_counter (params WIDTH; ports clk, rstn, inc, clr, count, sat).
REQ-034 The detection path SHALL be a shift register plus fill counter with no per-pattern hand-coded FSM states.

Verification
REQ-035 PAT_LEN=4, pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7; match_count=2.
REQ-036 Same stream with overlap=0 -> one out pulse after bit 4 only; match_count=1.
REQ-037 rstn pulsed low after bits 1,0,1, then stream 1,0,1,1 -> no pulse until bit 4 after reset; match_count=1.
REQ-038 pat_load with pat_in=0110, then stream 0,1,1,0 with in_valid gaps -> out only after the 4th valid bit; gap cycles cause no pulse.
REQ-039 CNT_W=2 with 4 matches -> match_count=3 and cnt_sat=1 after the 3rd match and unchanged after the 4th; cnt_clr -> 0/0.
REQ-040 cnt_clr in the same cycle as a match-completing bit -> out pulses once next cycle; match_count=0.
